// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file micro-sequencer: opcodes, FSM
// encoding, instruction field layout and default widths.
package rf_seq_pkg;

    localparam int unsigned DW_DEF  = 8;
    localparam int unsigned AW_DEF  = 4;
    localparam int unsigned IW      = 16;
    localparam int unsigned OPW     = 4;
    localparam int unsigned IMM_W   = 8;

    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned RS_LSB  = 4;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [OPW-1:0] OP_NOP = 4'd0;
    localparam logic [OPW-1:0] OP_LDI = 4'd1;
    localparam logic [OPW-1:0] OP_MOV = 4'd2;
    localparam logic [OPW-1:0] OP_ADD = 4'd3;
    localparam logic [OPW-1:0] OP_SUB = 4'd4;
    localparam logic [OPW-1:0] OP_AND = 4'd5;
    localparam logic [OPW-1:0] OP_OR  = 4'd6;
    localparam logic [OPW-1:0] OP_XOR = 4'd7;
    localparam logic [OPW-1:0] OP_NOT = 4'd8;
    localparam logic [OPW-1:0] OP_OUT = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RDA  = 3'd1,
        ST_RDB  = 3'd2,
        ST_EXEC = 3'd3,
        ST_WR   = 3'd4,
        ST_EMIT = 3'd5
    } state_t;

    // Opcode field of a raw instruction word.
    function automatic logic [OPW-1:0] op_of(input logic [IW-1:0] word);
        return word[OP_LSB +: OPW];
    endfunction

    // Ops that read rd, compute, write rd back and update the flags.
    function automatic logic is_alu_op(input logic [OPW-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational ALU for the sequencer; MOV/OUT and unused codes pass opb through.
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic [OPW-1:0] op,
    input  logic [DW-1:0]  opa,
    input  logic [DW-1:0]  opb,
    output logic [DW-1:0]  result,
    output logic           z,
    output logic           c
);

    logic [DW:0] sum;

    always_comb begin
        sum    = {1'b0, opa} + {1'b0, opb};
        result = opb;
        c      = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[DW-1:0];
                c      = sum[DW];
            end
            OP_SUB: begin
                result = opa - opb;
                c      = (opa < opb);
            end
            OP_AND:  result = opa & opb;
            OP_OR:   result = opa | opb;
            OP_XOR:  result = opa ^ opb;
            OP_NOT:  result = ~opa;
            default: ;
        endcase
        z = (result == '0);
    end

endmodule

// File: rtl/rf_seq_ctrl.sv
// Micro-sequencer driving the single shared port of the 16x8 register file:
// accepts instructions, reads operands, executes, writes back or emits a result.
module rf_seq_ctrl
    import rf_seq_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] instr,
    input  logic          instr_valid,
    output logic          instr_ready,
    output logic          rf_enb,
    output logic          rf_r_w,
    output logic [AW-1:0] rf_sel,
    output logic [DW-1:0] rf_in,
    input  logic [DW-1:0] rf_out,
    output logic [DW-1:0] res,
    output logic          res_valid,
    output logic          flag_z,
    output logic          flag_c,
    output logic          busy
);

    state_t         state;
    logic [IW-1:0]  ir;
    logic [DW-1:0]  opa_q;
    logic [DW-1:0]  res_q;

    logic [OPW-1:0] op;
    logic [AW-1:0]  rd;
    logic [AW-1:0]  rs;
    logic [DW-1:0]  imm;
    logic [OPW-1:0] in_op;

    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_res;
    logic           alu_z;
    logic           alu_c;

    assign op    = op_of(ir);
    assign rd    = AW'(ir[RD_LSB +: 4]);
    assign rs    = AW'(ir[RS_LSB +: 4]);
    assign imm   = DW'(ir[IMM_LSB +: IMM_W]);
    assign in_op = op_of(instr);

    // NOT skips RDB, so its only operand arrives straight on rf_out in EXEC.
    assign alu_a = (op == OP_NOT) ? rf_out : opa_q;

    rf_seq_alu #(.DW(DW)) u_alu (
        .op     (op),
        .opa    (alu_a),
        .opb    (rf_out),
        .result (alu_res),
        .z      (alu_z),
        .c      (alu_c)
    );

    // Sequencer state, operand/result registers, flags and emitted result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ir        <= '0;
            opa_q     <= '0;
            res_q     <= '0;
            res       <= '0;
            res_valid <= 1'b0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        ir <= instr;
                        if (in_op == OP_LDI) begin
                            state <= ST_WR;
                        end else if ((in_op == OP_MOV) || (in_op == OP_OUT)) begin
                            state <= ST_RDB;
                        end else if (is_alu_op(in_op)) begin
                            state <= ST_RDA;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_RDA: begin
                    state <= (op == OP_NOT) ? ST_EXEC : ST_RDB;
                end
                ST_RDB: begin
                    opa_q <= rf_out;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_q <= alu_res;
                    if (is_alu_op(op)) begin
                        flag_z <= alu_z;
                        flag_c <= alu_c;
                    end
                    state <= (op == OP_OUT) ? ST_EMIT : ST_WR;
                end
                ST_WR: begin
                    state <= ST_IDLE;
                end
                ST_EMIT: begin
                    res       <= res_q;
                    res_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Register-file port is a pure decode of the state register and ir.
    always_comb begin
        rf_enb = 1'b0;
        rf_r_w = 1'b1;
        rf_sel = '0;
        rf_in  = '0;
        case (state)
            ST_RDA: begin
                rf_enb = 1'b1;
                rf_sel = rd;
            end
            ST_RDB: begin
                rf_enb = 1'b1;
                rf_sel = rs;
            end
            ST_WR: begin
                rf_enb = 1'b1;
                rf_r_w = 1'b0;
                rf_sel = rd;
                rf_in  = (op == OP_LDI) ? imm : res_q;
            end
            default: ;
        endcase
    end

    assign instr_ready = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// Self-checking bench for rf_seq_ctrl with a behavioural 16x8 register file.
module tb_rf_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        rf_enb;
    logic        rf_r_w;
    logic [3:0]  rf_sel;
    logic [7:0]  rf_in;
    logic [7:0]  rf_out = 8'h00;
    logic [7:0]  res;
    logic        res_valid;
    logic        flag_z;
    logic        flag_c;
    logic        busy;

    int errors = 0;
    int checks = 0;

    rf_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .rf_enb      (rf_enb),
        .rf_r_w      (rf_r_w),
        .rf_sel      (rf_sel),
        .rf_in       (rf_in),
        .rf_out      (rf_out),
        .res         (res),
        .res_valid   (res_valid),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Register file model: registered read data, write on enable with r_w=0.
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (rf_enb) begin
            if (rf_r_w) rf_out <= mem[rf_sel];
            else        mem[rf_sel] <= rf_in;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus activity observed mid-cycle.
    int         enb_cnt = 0;
    int         wr_cnt  = 0;
    int         res_cnt = 0;
    int         res_cyc = 0;
    logic [3:0] last_sel;
    logic [7:0] last_wdata;
    logic [7:0] last_res;
    always @(negedge clk) begin
        if (rf_enb) enb_cnt++;
        if (rf_enb && !rf_r_w) begin
            wr_cnt++;
            last_sel   = rf_sel;
            last_wdata = rf_in;
        end
        if (res_valid) begin
            res_cnt++;
            last_res = res;
            res_cyc  = cyc;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] instr;
        int          lat;
        int          enb;
        bit          wr;
        logic [3:0]  sel;
        logic [7:0]  wdata;
        bit          rv;
        logic [7:0]  res;
        bit          z;
        bit          c;
    } vec_t;

    vec_t tbl [19];

    // One instruction through a full handshake, then check bus, result and flags.
    task automatic issue(input vec_t v);
        int n;
        int e0;
        int w0;
        int r0;
        e0 = enb_cnt;
        w0 = wr_cnt;
        r0 = res_cnt;
        chk("ready_before_issue", int'(instr_ready), 1);
        instr       = v.instr;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 16'h3FFF;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n + 1, v.lat);
        @(negedge clk);
        #1;
        chk("rf_access_cycles", enb_cnt - e0, v.enb);
        chk("rf_writes", wr_cnt - w0, int'(v.wr));
        if (v.wr) begin
            chk("wr_sel", int'(last_sel), int'(v.sel));
            chk("wr_data", int'(last_wdata), int'(v.wdata));
        end
        chk("res_pulses", res_cnt - r0, int'(v.rv));
        if (v.rv) chk("res_value", int'(last_res), int'(v.res));
        chk("flag_z", int'(flag_z), int'(v.z));
        chk("flag_c", int'(flag_c), int'(v.c));
    endtask

    // Stream instructions with instr_valid held high; record accept cycles.
    logic [15:0] sq  [4];
    int          acc [4];
    task automatic stream(input int n);
        int g;
        for (int k = 0; k < n; k++) begin
            instr       = sq[k];
            instr_valid = 1'b1;
            g = 0;
            while (!instr_ready && g < 20) begin
                @(negedge clk);
                #1;
                g++;
            end
            chk("stream_accept_timeout", int'(g < 20), 1);
            acc[k] = cyc;
            @(negedge clk);
            #1;
        end
        instr_valid = 1'b0;
        g = 0;
        while (busy && g < 20) begin
            @(negedge clk);
            #1;
            g++;
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e0;
        int w0;
        int r0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        tbl[0]  = '{16'h135A, 2, 1, 1, 4'h3, 8'h5A, 0, 8'h00, 0, 0}; // LDI R3,5A
        tbl[1]  = '{16'h9030, 4, 1, 0, 4'h0, 8'h00, 1, 8'h5A, 0, 0}; // OUT R3
        tbl[2]  = '{16'h11F0, 2, 1, 1, 4'h1, 8'hF0, 0, 8'h00, 0, 0}; // LDI R1,F0
        tbl[3]  = '{16'h1220, 2, 1, 1, 4'h2, 8'h20, 0, 8'h00, 0, 0}; // LDI R2,20
        tbl[4]  = '{16'h3120, 5, 3, 1, 4'h1, 8'h10, 0, 8'h00, 0, 1}; // ADD R1,R2
        tbl[5]  = '{16'h4110, 5, 3, 1, 4'h1, 8'h00, 0, 8'h00, 1, 0}; // SUB R1,R1
        tbl[6]  = '{16'h140F, 2, 1, 1, 4'h4, 8'h0F, 0, 8'h00, 1, 0}; // LDI R4,0F
        tbl[7]  = '{16'h8400, 4, 2, 1, 4'h4, 8'hF0, 0, 8'h00, 0, 0}; // NOT R4
        tbl[8]  = '{16'h2540, 4, 2, 1, 4'h5, 8'hF0, 0, 8'h00, 0, 0}; // MOV R5,R4
        tbl[9]  = '{16'h9050, 4, 1, 0, 4'h0, 8'h00, 1, 8'hF0, 0, 0}; // OUT R5
        tbl[10] = '{16'hC123, 1, 0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 0}; // illegal op C
        tbl[11] = '{16'h0000, 1, 0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 0}; // NOP
        tbl[12] = '{16'h4120, 5, 3, 1, 4'h1, 8'hE0, 0, 8'h00, 0, 1}; // SUB R1,R2 borrow
        tbl[13] = '{16'h5120, 5, 3, 1, 4'h1, 8'h20, 0, 8'h00, 0, 0}; // AND R1,R2
        tbl[14] = '{16'h6430, 5, 3, 1, 4'h4, 8'hFA, 0, 8'h00, 0, 0}; // OR R4,R3
        tbl[15] = '{16'h7220, 5, 3, 1, 4'h2, 8'h00, 0, 8'h00, 1, 0}; // XOR R2,R2
        tbl[16] = '{16'h3550, 5, 3, 1, 4'h5, 8'hE0, 0, 8'h00, 0, 1}; // ADD R5,R5
        tbl[17] = '{16'h1F77, 2, 1, 1, 4'hF, 8'h77, 0, 8'h00, 0, 1}; // LDI R15,77
        tbl[18] = '{16'h90F0, 4, 1, 0, 4'h0, 8'h00, 1, 8'h77, 0, 1}; // OUT R15

        rst         = 1'b1;
        instr       = 16'h0000;
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_instr_ready", int'(instr_ready), 1);
        chk("rst_rf_enb", int'(rf_enb), 0);
        chk("rst_rf_r_w", int'(rf_r_w), 1);
        chk("rst_rf_sel", int'(rf_sel), 0);
        chk("rst_rf_in", int'(rf_in), 0);
        chk("rst_res", int'(res), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_flags", int'({flag_z, flag_c}), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;

        for (int i = 0; i < 19; i++) issue(tbl[i]);

        // Held-valid queue: LDI R6,33; illegal C; OUT R6.
        e0 = enb_cnt;
        r0 = res_cnt;
        sq[0] = 16'h1633;
        sq[1] = 16'hC000;
        sq[2] = 16'h9060;
        stream(3);
        chk("hs_spacing_ldi", acc[1] - acc[0], 2);
        chk("hs_spacing_nop", acc[2] - acc[1], 1);
        chk("hs_rf_access_cycles", enb_cnt - e0, 2);
        chk("hs_res_pulses", res_cnt - r0, 1);
        chk("hs_res_delay", res_cyc - acc[2], 4);
        chk("hs_res_value", int'(last_res), 8'h33);

        // Back-to-back LDI R15,01 then OUT R15.
        r0 = res_cnt;
        sq[0] = 16'h1F01;
        sq[1] = 16'h90F0;
        stream(2);
        chk("b2b_spacing", acc[1] - acc[0], 2);
        chk("b2b_res_pulses", res_cnt - r0, 1);
        chk("b2b_res_delay", res_cyc - acc[1], 4);
        chk("b2b_res_value", int'(last_res), 8'h01);

        // Reset in RDB of ADD R7,R8 must drop the instruction.
        issue('{16'h1711, 2, 1, 1, 4'h7, 8'h11, 0, 8'h00, 0, 1});
        issue('{16'h1822, 2, 1, 1, 4'h8, 8'h22, 0, 8'h00, 0, 1});
        w0 = wr_cnt;
        instr       = 16'h3780;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_add_busy", int'(busy), 1);
        chk("mid_add_rf_sel", int'(rf_sel), 8);
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_instr_ready", int'(instr_ready), 1);
        chk("midrst_rf_enb", int'(rf_enb), 0);
        chk("midrst_flags", int'({flag_z, flag_c}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        chk("midrst_no_write", wr_cnt - w0, 0);
        chk("midrst_r7_kept", int'(mem[7]), 8'h11);
        chk("midrst_idle", int'(instr_ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
